// File: rtl/hazard_unit_pkg.sv
// Shared types for the hazard unit: register address width, x0, shadow-stage
// records and the load-use FSM states.
package hazard_unit_pkg;

  localparam int REG_AW = 5;
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  // Destination-side view of an instruction, kept in EX, MEM and WB.
  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              load;
  } stage_t;

  // EX additionally remembers its sources so the operand mux can be steered.
  typedef struct packed {
    stage_t            dst;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              rs1_used;
    logic              rs2_used;
  } ex_stage_t;

  typedef enum logic {
    RUN      = 1'b0,
    LU_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. master = pipeline side,
// slave = hazard unit side.
interface hazard_unit_if import hazard_unit_pkg::*; ();

  logic              i_id_valid;
  logic [REG_AW-1:0] i_id_rs1_raddr;
  logic [REG_AW-1:0] i_id_rs2_raddr;
  logic              i_id_rs1_used;
  logic              i_id_rs2_used;
  logic [REG_AW-1:0] i_id_rd_waddr;
  logic              i_id_rd_wen;
  logic              i_id_mem_read;
  logic              i_ex_redirect;
  logic              o_stall;
  logic              o_flush;
  logic              o_frwd_alu_op1;
  logic              o_frwd_mem_op1;
  logic              o_frwd_alu_op2;
  logic              o_frwd_mem_op2;

  modport master (
    output i_id_valid, i_id_rs1_raddr, i_id_rs2_raddr, i_id_rs1_used, i_id_rs2_used,
           i_id_rd_waddr, i_id_rd_wen, i_id_mem_read, i_ex_redirect,
    input  o_stall, o_flush, o_frwd_alu_op1, o_frwd_mem_op1, o_frwd_alu_op2, o_frwd_mem_op2
  );

  modport slave (
    input  i_id_valid, i_id_rs1_raddr, i_id_rs2_raddr, i_id_rs1_used, i_id_rs2_used,
           i_id_rd_waddr, i_id_rd_wen, i_id_mem_read, i_ex_redirect,
    output o_stall, o_flush, o_frwd_alu_op1, o_frwd_mem_op1, o_frwd_alu_op2, o_frwd_mem_op2
  );

endinterface

// File: rtl/hazard_unit_match.sv
// One producer/consumer register compare: a producer stage writes the
// register a consumer actually reads, and that register is not x0.
module hazard_match import hazard_unit_pkg::*; (
  input  logic              valid,
  input  logic              wen,
  input  logic [REG_AW-1:0] rd,
  input  logic [REG_AW-1:0] rs,
  input  logic              used,
  output logic              match
);

  assign match = valid & wen & used & (rd != REG_X0) & (rd == rs);

endmodule

// File: rtl/hazard_unit.sv
// Hazard unit: shadow EX/MEM/WB stages, forwarding selects and stall/flush.
// HAZARD_UNIT_FRWD_EN enables forwarding; otherwise dependences stall.
module hazard_unit import hazard_unit_pkg::*; (
  input  logic          i_clk,
  input  logic          i_rst,
  hazard_unit_if.slave  bus
);

  ex_stage_t ex_reg, ex_next;
  stage_t    mem_reg, wb_reg;
  state_t    state_reg, state_next;

  logic       stall, flush, hazard;
  logic [1:0] ex_id_match;
  logic [1:0] fwd_alu, fwd_mem;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      hazard_match u_ex_id (
        .valid (ex_reg.dst.valid),
        .wen   (ex_reg.dst.wen),
        .rd    (ex_reg.dst.rd),
        .rs    ((gi == 0) ? bus.i_id_rs1_raddr : bus.i_id_rs2_raddr),
        .used  ((gi == 0) ? bus.i_id_rs1_used  : bus.i_id_rs2_used),
        .match (ex_id_match[gi])
      );
`ifdef HAZARD_UNIT_FRWD_EN
      logic mem_ex_match, wb_ex_match;
      hazard_match u_mem_ex (
        .valid (mem_reg.valid),
        .wen   (mem_reg.wen),
        .rd    (mem_reg.rd),
        .rs    ((gi == 0) ? ex_reg.rs1 : ex_reg.rs2),
        .used  ((gi == 0) ? ex_reg.rs1_used : ex_reg.rs2_used),
        .match (mem_ex_match)
      );
      hazard_match u_wb_ex (
        .valid (wb_reg.valid),
        .wen   (wb_reg.wen),
        .rd    (wb_reg.rd),
        .rs    ((gi == 0) ? ex_reg.rs1 : ex_reg.rs2),
        .used  ((gi == 0) ? ex_reg.rs1_used : ex_reg.rs2_used),
        .match (wb_ex_match)
      );
      // The younger producer (MEM) holds the newer value.
      assign fwd_alu[gi] = mem_ex_match;
      assign fwd_mem[gi] = wb_ex_match & ~mem_ex_match;
`else
      logic mem_id_match;
      hazard_match u_mem_id (
        .valid (mem_reg.valid),
        .wen   (mem_reg.wen),
        .rd    (mem_reg.rd),
        .rs    ((gi == 0) ? bus.i_id_rs1_raddr : bus.i_id_rs2_raddr),
        .used  ((gi == 0) ? bus.i_id_rs1_used  : bus.i_id_rs2_used),
        .match (mem_id_match)
      );
      assign fwd_alu[gi] = 1'b0;
      assign fwd_mem[gi] = 1'b0;
`endif
    end
  endgenerate

`ifdef HAZARD_UNIT_FRWD_EN
  assign hazard = bus.i_id_valid & ex_reg.dst.load & (|ex_id_match);
  logic unused_bits;
  assign unused_bits = ^{mem_reg.load, wb_reg.load};
`else
  // WB needs no stall: the register file writes through to the read port.
  assign hazard = bus.i_id_valid & ((|ex_id_match) | g_op[0].mem_id_match | g_op[1].mem_id_match);
  logic unused_bits;
  assign unused_bits = ^{mem_reg.load, wb_reg, ex_reg.rs1, ex_reg.rs2,
                         ex_reg.rs1_used, ex_reg.rs2_used, ex_reg.dst.load};
`endif

  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    flush      = 1'b0;
    if (bus.i_ex_redirect) begin
      flush      = 1'b1;
      state_next = RUN;
    end else begin
      case (state_reg)
        RUN: begin
          if (hazard) begin
            stall      = 1'b1;
            state_next = LU_STALL;
          end
        end
        LU_STALL: begin
`ifndef HAZARD_UNIT_FRWD_EN
          // Producer has moved to MEM; the dependence may still be live.
          stall = hazard;
`endif
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    ex_next = '0;
    if (!(stall || flush)) begin
      ex_next.dst.valid = bus.i_id_valid;
      ex_next.dst.rd    = bus.i_id_rd_waddr;
      ex_next.dst.wen   = bus.i_id_rd_wen;
      ex_next.dst.load  = bus.i_id_mem_read;
      ex_next.rs1       = bus.i_id_rs1_raddr;
      ex_next.rs2       = bus.i_id_rs2_raddr;
      ex_next.rs1_used  = bus.i_id_rs1_used;
      ex_next.rs2_used  = bus.i_id_rs2_used;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg <= RUN;
      ex_reg    <= '0;
      mem_reg   <= '0;
      wb_reg    <= '0;
    end else begin
      state_reg <= state_next;
      ex_reg    <= ex_next;
      mem_reg   <= ex_reg.dst;
      wb_reg    <= mem_reg;
    end
  end

  assign bus.o_stall        = stall;
  assign bus.o_flush        = flush;
  assign bus.o_frwd_alu_op1 = fwd_alu[0];
  assign bus.o_frwd_mem_op1 = fwd_mem[0];
  assign bus.o_frwd_alu_op2 = fwd_alu[1];
  assign bus.o_frwd_mem_op2 = fwd_mem[1];

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: an instruction-level model checked every
// cycle, plus literal expectations for the classic hazard sequences.
module tb_hazard_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_unit_if bus ();

  hazard_unit dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  typedef struct {
    bit       valid;
    bit [4:0] rd;
    bit       wen;
    bit       load;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
  } ins_t;

  ins_t id_cur, m_ex, m_mem, m_wb;
  bit   redir_cur = 1'b0;
  bit   model_on  = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   cycle  = 0;

  function automatic ins_t mk(int v, int rd, int w, int l, int a, int b, int u1, int u2);
    ins_t r;
    r.valid = (v != 0);
    r.rd    = 5'(rd);
    r.wen   = (w != 0);
    r.load  = (l != 0);
    r.rs1   = 5'(a);
    r.rs2   = 5'(b);
    r.u1    = (u1 != 0);
    r.u2    = (u2 != 0);
    return r;
  endfunction

  function automatic ins_t alu(int rd, int a, int b);
    return mk(1, rd, 1, 0, a, b, 1, 1);
  endfunction

  function automatic ins_t ld(int rd, int a);
    return mk(1, rd, 1, 1, a, 0, 1, 0);
  endfunction

  function automatic ins_t bub();
    return mk(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Does producer p supply register r to a consumer that reads it?
  function automatic bit writes(ins_t p, bit [4:0] r, bit used);
    return used && p.valid && p.wen && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  // Expected {stall, flush, alu1, mem1, alu2, mem2} from instruction positions.
  function automatic bit [5:0] model_out(ins_t id, bit redir);
    bit a1, m1, a2, m2, st;
    a1 = 1'b0; m1 = 1'b0; a2 = 1'b0; m2 = 1'b0;
`ifdef HAZARD_UNIT_FRWD_EN
    a1 = writes(m_mem, m_ex.rs1, m_ex.u1);
    m1 = !a1 && writes(m_wb, m_ex.rs1, m_ex.u1);
    a2 = writes(m_mem, m_ex.rs2, m_ex.u2);
    m2 = !a2 && writes(m_wb, m_ex.rs2, m_ex.u2);
    st = id.valid && m_ex.load &&
         (writes(m_ex, id.rs1, id.u1) || writes(m_ex, id.rs2, id.u2));
`else
    st = id.valid && (writes(m_ex, id.rs1, id.u1) || writes(m_ex, id.rs2, id.u2) ||
                      writes(m_mem, id.rs1, id.u1) || writes(m_mem, id.rs2, id.u2));
`endif
    if (redir) st = 1'b0;
    return {st, redir, a1, m1, a2, m2};
  endfunction

  function automatic bit [5:0] dut_vec();
    return {bus.o_stall, bus.o_flush, bus.o_frwd_alu_op1, bus.o_frwd_mem_op1,
            bus.o_frwd_alu_op2, bus.o_frwd_mem_op2};
  endfunction

  always @(posedge clk) begin : model_step
    bit [5:0] e;
    e = model_out(id_cur, redir_cur);
    cycle <= cycle + 1;
    if (rst) begin
      m_ex  <= bub();
      m_mem <= bub();
      m_wb  <= bub();
    end else begin
      m_ex  <= (e[5] || e[4]) ? bub() : id_cur;
      m_mem <= m_ex;
      m_wb  <= m_mem;
    end
  end

  always @(negedge clk) begin : model_cmp
    bit [5:0] e, g;
    if (model_on) begin
      e = model_out(id_cur, redir_cur);
      g = dut_vec();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL model cyc=%0d got={st,fl,a1,m1,a2,m2}=%b want=%b", cycle, g, e);
      end
    end
  end

  task automatic drive(ins_t i, bit r);
    id_cur                 = i;
    redir_cur              = r;
    bus.i_id_valid         = i.valid;
    bus.i_id_rd_waddr      = i.rd;
    bus.i_id_rd_wen        = i.wen;
    bus.i_id_mem_read      = i.load;
    bus.i_id_rs1_raddr     = i.rs1;
    bus.i_id_rs2_raddr     = i.rs2;
    bus.i_id_rs1_used      = i.u1;
    bus.i_id_rs2_used      = i.u2;
    bus.i_ex_redirect      = r;
  endtask

  // One clock with ID=i; exp<0 leaves the cycle to the model only.
  task automatic cyc(string name, ins_t i, bit r, int exp);
    bit [5:0] g, w;
    drive(i, r);
    @(negedge clk);
    g = dut_vec();
    w = exp[5:0];
    if (exp >= 0) begin
      checks++;
      if (g !== w) begin
        errors++;
        $display("FAIL %s got={st,fl,a1,m1,a2,m2}=%b want=%b", name, g, w);
      end else begin
        $display("ok   %s outputs=%b", name, g);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(bub(), 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_on = 1'b1;

    cyc("reset_idle", alu(5, 1, 2), 1'b0, 6'b000000);

`ifdef HAZARD_UNIT_FRWD_EN
    cyc("fw_nop0", bub(), 1'b0, -1);
    cyc("fw_nop1", bub(), 1'b0, -1);
    // add x5 -> sub x6,x5,x3
    cyc("alu_fwd_prod", alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("alu_fwd_cons", alu(6, 5, 3), 1'b0, 6'b000000);
    cyc("alu_fwd_op1",  bub(),        1'b0, 6'b001000);
    cyc("drain0",       bub(),        1'b0, -1);
    cyc("drain1",       bub(),        1'b0, -1);
    // add x5, nop, and x7,x4,x5
    cyc("mem_fwd_prod", alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("mem_fwd_gap",  bub(),        1'b0, 6'b000000);
    cyc("mem_fwd_cons", alu(7, 4, 5), 1'b0, 6'b000000);
    cyc("mem_fwd_op2",  bub(),        1'b0, 6'b000001);
    cyc("drain2",       bub(),        1'b0, -1);
    cyc("drain3",       bub(),        1'b0, -1);
    // lw x5 -> add x6,x5,x5
    cyc("lu_load",      ld(5, 1),     1'b0, 6'b000000);
    cyc("lu_stall",     alu(6, 5, 5), 1'b0, 6'b100000);
    cyc("lu_held",      alu(6, 5, 5), 1'b0, 6'b000000);
    cyc("lu_wb_fwd",    bub(),        1'b0, 6'b000101);
    cyc("drain4",       bub(),        1'b0, -1);
    cyc("drain5",       bub(),        1'b0, -1);
    // x0 never forwards
    cyc("x0_prod",      alu(0, 1, 2), 1'b0, 6'b000000);
    cyc("x0_cons",      alu(3, 0, 0), 1'b0, 6'b000000);
    cyc("x0_nofwd",     bub(),        1'b0, 6'b000000);
    cyc("drain6",       bub(),        1'b0, -1);
    cyc("drain7",       bub(),        1'b0, -1);
    // redirect beats load-use
    cyc("rd_load",      ld(5, 1),     1'b0, 6'b000000);
    cyc("rd_redirect",  alu(6, 5, 5), 1'b1, 6'b010000);
    cyc("rd_after",     alu(8, 6, 6), 1'b0, 6'b000000);
    cyc("rd_bubbled",   bub(),        1'b0, 6'b000000);
    cyc("drain8",       bub(),        1'b0, -1);
    cyc("drain9",       bub(),        1'b0, -1);
`else
    cyc("nf_nop0", bub(), 1'b0, -1);
    cyc("nf_nop1", bub(), 1'b0, -1);
    // add x5 -> sub x6,x5,x5 stalls two cycles
    cyc("dep_prod",     alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("dep_stall1",   alu(6, 5, 5), 1'b0, 6'b100000);
    cyc("dep_stall2",   alu(6, 5, 5), 1'b0, 6'b100000);
    cyc("dep_release",  alu(6, 5, 5), 1'b0, 6'b000000);
    cyc("dep_nofwd",    bub(),        1'b0, 6'b000000);
    cyc("drain0",       bub(),        1'b0, -1);
    cyc("drain1",       bub(),        1'b0, -1);
    // producer two ahead: only MEM dependence, one stall
    cyc("mem_prod",     alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("mem_gap",      alu(7, 1, 2), 1'b0, 6'b000000);
    cyc("mem_stall",    alu(8, 5, 0), 1'b0, 6'b100000);
    cyc("mem_release",  alu(8, 5, 0), 1'b0, 6'b000000);
    cyc("drain2",       bub(),        1'b0, -1);
    cyc("drain3",       bub(),        1'b0, -1);
    // unused source never stalls
    cyc("unused_prod",  alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("unused_src",   mk(1, 9, 1, 0, 9, 5, 1, 0), 1'b0, 6'b000000);
    cyc("drain4",       bub(),        1'b0, -1);
    cyc("drain5",       bub(),        1'b0, -1);
    // x0 never stalls
    cyc("x0_prod",      alu(0, 1, 2), 1'b0, 6'b000000);
    cyc("x0_cons",      alu(3, 0, 0), 1'b0, 6'b000000);
    cyc("drain6",       bub(),        1'b0, -1);
    cyc("drain7",       bub(),        1'b0, -1);
    // redirect overrides a dependence stall and bubbles EX
    cyc("rd_prod",      alu(5, 1, 2), 1'b0, 6'b000000);
    cyc("rd_redirect",  alu(6, 5, 5), 1'b1, 6'b010000);
    cyc("rd_bubbled",   alu(7, 6, 6), 1'b0, 6'b000000);
    cyc("drain8",       bub(),        1'b0, -1);
    cyc("drain9",       bub(),        1'b0, -1);
`endif

    // reset while a dependence stall is in progress
    cyc("rs_load",      ld(5, 1),     1'b0, 6'b000000);
    cyc("rs_stall",     alu(6, 5, 5), 1'b0, 6'b100000);
    rst = 1'b1;
    cyc("rs_in_reset",  alu(6, 5, 5), 1'b0, -1);
    rst = 1'b0;
    cyc("rs_empty",     alu(6, 5, 5), 1'b0, 6'b000000);
    cyc("rs_after",     bub(),        1'b0, 6'b000000);
    cyc("drain10",      bub(),        1'b0, -1);

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
